// File: rtl/rf_wb_scheduler_if.sv
// Writeback scheduler bundle: two writeback requesters, issue/hazard query, regfile write port.
// Pure wiring; master drives requests/queries, slave (the scheduler) answers.
// Backpressure via a_ready/b_ready returned on the slave side.
interface rf_wb_scheduler_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        hazard;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] pending;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output iss_valid, iss_rd, chk_rs1, chk_rs2,
    input  a_ready, b_ready, hazard, RegWrite, rd, write_data, pending
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2,
    output a_ready, b_ready, hazard, RegWrite, rd, write_data, pending
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Arbitrates ALU (A) and load (B) writebacks onto one regfile port and tracks pending destinations.
// Latency: grant is combinational, RegWrite/rd/write_data registered 1 cycle after the transfer.
// Backpressure: at most one of a_ready/b_ready per cycle; WB_RR_EN selects round-robin, else A-priority with B starvation guard.
module rf_wb_scheduler #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  rf_wb_scheduler_if.slave wb
);

  logic        a_win;
  logic        a_go;
  logic        b_go;
  logic        xfer;
  logic [4:0]  g_rd;
  logic [31:0] g_data;
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic        reg_write_q;
  logic [4:0]  rd_q;
  logic [31:0] wd_q;
  logic        hz1;
  logic        hz2;

`ifdef WB_RR_EN
  // last_b=1 means B was granted the last conflict, so A takes the next one.
  logic last_b;
  assign a_win = last_b;

  always_ff @(posedge clk) begin
    if (rst)
      last_b <= 1'b1;
    else if (wb.a_valid && wb.b_valid)
      last_b <= b_go;
  end
`else
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  logic [CW-1:0] starve_cnt;
  assign a_win = (int'(starve_cnt) < STARVE_LIMIT);

  // Counts consecutive cycles B was valid but denied; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst || b_go || !wb.b_valid)
      starve_cnt <= '0;
    else if (int'(starve_cnt) < STARVE_LIMIT)
      starve_cnt <= starve_cnt + CW'(1);
  end
`endif

  assign a_go   = !rst && wb.a_valid && (!wb.b_valid || a_win);
  assign b_go   = !rst && wb.b_valid && !(wb.a_valid && a_win);
  assign xfer   = a_go || b_go;
  assign g_rd   = a_go ? wb.a_rd   : wb.b_rd;
  assign g_data = a_go ? wb.a_data : wb.b_data;

  assign wb.a_ready = a_go;
  assign wb.b_ready = b_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wd_q        <= '0;
    end else if (xfer) begin
      reg_write_q <= (g_rd != 5'd0);
      rd_q        <= g_rd;
      wd_q        <= g_data;
    end else begin
      reg_write_q <= 1'b0;
    end
  end

  // Issue is applied after the writeback clear so a same-cycle set survives.
  always_comb begin
    pending_d = pending_q;
    if (xfer)
      pending_d[g_rd] = 1'b0;
    if (wb.iss_valid)
      pending_d[wb.iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pending_q <= '0;
    else
      pending_q <= pending_d;
  end

  // The registered write is not yet visible in the regfile, so it counts as a hazard too.
  always_comb begin
    hz1 = (wb.chk_rs1 != 5'd0) &&
          (pending_q[wb.chk_rs1] || (reg_write_q && (rd_q == wb.chk_rs1)));
    hz2 = (wb.chk_rs2 != 5'd0) &&
          (pending_q[wb.chk_rs2] || (reg_write_q && (rd_q == wb.chk_rs2)));
  end

  assign wb.hazard     = hz1 || hz2;
  assign wb.RegWrite   = reg_write_q;
  assign wb.rd         = rd_q;
  assign wb.write_data = wd_q;
  assign wb.pending    = pending_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: expected writebacks queued at grant, checked one cycle later.
module tb_rf_wb_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_scheduler_if wb ();

  rf_wb_scheduler #(.STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wb.a_valid = 1'b0; wb.a_rd = 5'd0; wb.a_data = 32'd0;
    wb.b_valid = 1'b0; wb.b_rd = 5'd0; wb.b_data = 32'd0;
    wb.iss_valid = 1'b0; wb.iss_rd = 5'd0;
    wb.chk_rs1 = 5'd0; wb.chk_rs2 = 5'd0;
  endtask

  task automatic set_a(input logic [4:0] r, input logic [31:0] d);
    wb.a_valid = 1'b1; wb.a_rd = r; wb.a_data = d;
  endtask

  task automatic set_b(input logic [4:0] r, input logic [31:0] d);
    wb.b_valid = 1'b1; wb.b_rd = r; wb.b_data = d;
  endtask

  // One cycle: check combinational grant/hazard mid-cycle, then the registered writeback.
  task automatic step(input string tag, input logic ea, input logic eb, input logic ehz);
    wb_t w;
    #3;
    check({tag, "_a_ready"}, {31'd0, wb.a_ready}, {31'd0, ea});
    check({tag, "_b_ready"}, {31'd0, wb.b_ready}, {31'd0, eb});
    check({tag, "_hazard"},  {31'd0, wb.hazard},  {31'd0, ehz});
    if (ea) exp_q.push_back('{we: (wb.a_rd != 5'd0), rd: wb.a_rd, data: wb.a_data});
    if (eb) exp_q.push_back('{we: (wb.b_rd != 5'd0), rd: wb.b_rd, data: wb.b_data});
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check({tag, "_RegWrite"},   {31'd0, wb.RegWrite}, {31'd0, w.we});
      check({tag, "_rd"},         {27'd0, wb.rd},       {27'd0, w.rd});
      check({tag, "_write_data"}, wb.write_data,        w.data);
    end else begin
      check({tag, "_RegWrite_idle"}, {31'd0, wb.RegWrite}, 32'd0);
    end
  endtask

  logic [3:0] conf_a;
  logic [2:0] pre_a;

  initial begin
`ifdef WB_RR_EN
    conf_a = 4'b0101;  // bit i = A wins conflict i
    pre_a  = 3'b101;
`else
    conf_a = 4'b0111;
    pre_a  = 3'b111;
`endif
    idle();
    rst = 1'b1;
    set_a(5'd3, 32'hAAAA);
    step("reset", 1'b0, 1'b0, 1'b0);
    check("reset_rd", {27'd0, wb.rd}, 32'd0);
    check("reset_wdata", wb.write_data, 32'd0);
    check("reset_pending", wb.pending, 32'd0);
    rst = 1'b0;
    idle();

    // Lone A, then an idle cycle: RegWrite drops, rd/data hold.
    set_a(5'd5, 32'h1234);
    step("lone_a", 1'b1, 1'b0, 1'b0);
    idle();
    step("lone_a_idle", 1'b0, 1'b0, 1'b0);
    check("hold_rd", {27'd0, wb.rd}, 32'd5);
    check("hold_wdata", wb.write_data, 32'h1234);

    // Four back-to-back conflicts.
    for (int i = 0; i < 4; i++) begin
      set_a(5'(10 + i), 32'hA000 + 32'(i));
      set_b(5'(20 + i), 32'hB000 + 32'(i));
      step($sformatf("conflict%0d", i), conf_a[i], !conf_a[i], 1'b0);
    end
    idle();
    step("conflict_drain", 1'b0, 1'b0, 1'b0);

    // Lone B.
    set_b(5'd6, 32'h600D);
    step("lone_b", 1'b0, 1'b1, 1'b0);
    idle();

    // Issue rd 7, then hazard until the write is visible.
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd7;
    step("iss7", 1'b0, 1'b0, 1'b0);
    check("pending7_set", {31'd0, wb.pending[7]}, 32'd1);
    idle();
    wb.chk_rs1 = 5'd7;
    set_b(5'd7, 32'h7777);
    step("wb7", 1'b0, 1'b1, 1'b1);
    check("pending7_clr", {31'd0, wb.pending[7]}, 32'd0);
    idle();
    wb.chk_rs2 = 5'd7;
    step("wb7_regwrite_cycle", 1'b0, 1'b0, 1'b1);
    step("wb7_after", 1'b0, 1'b0, 1'b0);
    idle();

    // Issue and writeback to rd 9 in the same cycle: set wins.
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd9;
    step("iss9", 1'b0, 1'b0, 1'b0);
    set_a(5'd9, 32'h9999);
    step("iss9_wb9", 1'b1, 1'b0, 1'b0);
    check("pending9_kept", {31'd0, wb.pending[9]}, 32'd1);
    idle();

    // rd 0 transfer: accepted, no write; r0 never pending or hazardous.
    set_a(5'd0, 32'hDEAD);
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd0;
    step("rd0", 1'b1, 1'b0, 1'b0);
    check("pending0", {31'd0, wb.pending[0]}, 32'd0);
    idle();
    wb.chk_rs2 = 5'd9;
    step("hz_rs2_9", 1'b0, 1'b0, 1'b1);
    idle();

    // Build arbitration history, then reset during a would-be grant.
    for (int i = 0; i < 3; i++) begin
      set_a(5'd12, 32'hC0 + 32'(i));
      set_b(5'd13, 32'hD0 + 32'(i));
      step($sformatf("pre%0d", i), pre_a[i], !pre_a[i], 1'b0);
    end
    rst = 1'b1;
    step("rst_grant", 1'b0, 1'b0, 1'b0);
    check("rst_pending", wb.pending, 32'd0);
    rst = 1'b0;
    step("post_rst_conflict", 1'b1, 1'b0, 1'b0);
    idle();
    step("final_drain", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wb_scheduler.md
RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive B denials before B is forced to win (fixed-priority mode only).
REQ-002 SHALL have port clk, in, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports a_valid in 1, a_ready out 1, a_rd in 5, a_data in 32: requester A, the ALU writeback.
REQ-005 SHALL have ports b_valid in 1, b_ready out 1, b_rd in 5, b_data in 32: requester B, the load/multi-cycle writeback.
REQ-006 SHALL have ports iss_valid in 1, iss_rd in 5: issue of an instruction that will write iss_rd.
REQ-007 SHALL have ports chk_rs1 in 5, chk_rs2 in 5, hazard out 1: operand hazard query.
REQ-008 SHALL have ports RegWrite out 1, rd out 5, write_data out 32: drive the register file write port directly.
REQ-009 SHALL have port pending out 32: scoreboard of outstanding destination registers.

Function
REQ-010 SHALL complete a transfer on a requester in any cycle where its valid and ready are both 1.
REQ-011 SHALL derive a_ready/b_ready combinationally; at most one is 1 per cycle; a lone valid requester is always granted.
REQ-012 SHALL, on a granted transfer, register RegWrite=(granted rd!=0), rd, write_data at that posedge: 1-cycle latency, RegWrite high for exactly one cycle per transfer.
REQ-013 SHALL deassert RegWrite in any cycle following a cycle with no transfer; rd/write_data hold their last value.
REQ-014 SHALL complete a transfer with rd==0 normally but produce no RegWrite pulse.
REQ-015 SHALL, when both valid, arbitrate per REQ-026/REQ-027.
REQ-016 SHALL not require requesters to hold valid; a dropped valid simply loses arbitration, with no state kept.
REQ-017 SHALL set pending[iss_rd] at posedge when iss_valid=1 and iss_rd!=0.
REQ-018 SHALL clear pending[x] at the posedge of a granted transfer with rd==x.
REQ-019 SHALL, when set and clear target the same index in one cycle, leave the bit set (set wins).
REQ-020 SHALL hold pending[0]=0 at all times.
REQ-021 SHALL assert hazard combinationally when, for either chk_rsN!=0, pending[chk_rsN]=1, or RegWrite=1 and rd==chk_rsN (write not yet visible in the register file).
REQ-022 SHALL never assert hazard for chk_rsN==0.
REQ-023 SHALL not check for duplicate issue to an already-pending rd; the bit stays set until the next matching writeback.

Reset
REQ-024 SHALL, while rst=1 at posedge, clear RegWrite, rd, write_data, pending, the round-robin pointer (pointing at B, so A wins the first conflict) and the starvation counter.
REQ-025 SHALL force a_ready=b_ready=0 while rst=1; a transfer in flight at reset is discarded, with no RegWrite pulse.

Configuration
REQ-026 SHALL, with macro WB_RR_EN defined, use round-robin: on conflict, grant the requester not granted last; the pointer updates only on a conflict grant; STARVE_LIMIT is unused.
REQ-027 SHALL, without WB_RR_EN, use fixed priority to A, except that after B has been denied STARVE_LIMIT consecutive valid cycles, B wins the next conflict. The counter resets on any B grant or any cycle with b_valid=0.

Verification
REQ-028 Lone A (a_rd=5, a_data=0x1234) -> a_ready=1 same cycle; next cycle RegWrite=1, rd=5, write_data=0x1234; cycle after that, RegWrite=0.
REQ-029 A and B valid together for 4 cycles -> with WB_RR_EN: grants A,B,A,B; without it, with STARVE_LIMIT=3: grants A,A,A,B.
REQ-030 iss_valid with iss_rd=7, then chk_rs1=7 -> hazard=1; B writes rd=7 -> pending[7] clears at grant edge; hazard stays 1 in the RegWrite cycle, then drops to 0.
REQ-031 iss_rd=9 issued in the same cycle as a granted writeback to rd=9 -> pending[9]=1 afterwards.
REQ-032 Transfer with a_rd=0 -> a_ready=1, no RegWrite pulse; chk_rs1=0 -> hazard=0 regardless of state.
REQ-033 rst asserted in the cycle of a grant -> next cycle RegWrite=0, pending=0; the first post-reset conflict is granted to A.
